demux1x4_reg: RTL and testbench
===============================

DEMUX1X4_REG -- requirements
Module: demux1x4_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_data, input, 8 bits: byte to distribute.
REQ-004 SHALL have port in_select, input, 2 bits: destination channel, 00 to 11 for channels 0 to 3.
REQ-005 SHALL have port in_bcast, input, 1 bit: 1 writes all four channels and ignores in_select.
REQ-006 SHALL have port in_valid, input, 1 bit: source offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept this cycle.
REQ-008 SHALL have ports out_0, out_1, out_2, out_3, outputs, 8 bits each: registered channel data.
REQ-009 SHALL have port out_valid, output, 4 bits: bit N set means out_N holds an unconsumed byte.
REQ-010 SHALL have port out_ready, input, 4 bits: bit N set means the channel-N consumer takes out_N this cycle.
REQ-011 SHALL have port xfer_count, output, 8 bits: number of accepted input transfers, modulo 256.

Function
REQ-012 SHALL keep one holding slot per channel, each either EMPTY or FULL; FULL is reflected by out_valid[N].
REQ-013 SHALL compute in_ready combinationally, for unicast, as !out_valid[sel] | out_ready[sel].
REQ-014 SHALL compute in_ready combinationally, for broadcast, as the AND over all N of (!out_valid[N] | out_ready[N]).
REQ-015 SHALL define an accept as in_valid & in_ready on a rising clock edge; in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL, on a unicast accept, load in_data into out_sel and set out_valid[sel] at that edge, giving 1-cycle latency.
REQ-017 SHALL, on a broadcast accept, load in_data into all four out_N and set all four out_valid bits at the same edge.
REQ-018 SHALL, on a drain (out_valid[N] & out_ready[N]) with no load to N, clear out_valid[N]; out_N SHALL retain its last value.
REQ-019 SHALL, on a simultaneous drain and load of the same channel, keep out_valid[N] at 1 and replace out_N with the new byte, with no bubble.
REQ-020 SHALL ignore out_ready[N] while out_valid[N] is 0, with no state change.
REQ-021 SHALL leave out_N and out_valid[N] unchanged for non-selected channels on a unicast accept; their drains proceed independently in the same cycle.
REQ-022 SHALL leave all slots and xfer_count unchanged when in_valid is 1 and in_ready is 0; the source holds its data.
REQ-023 SHALL increment xfer_count by 1 per accept, whether unicast or broadcast, wrapping 255 to 0 with no flag.
REQ-024 SHALL never overwrite a FULL slot that is not draining in the same cycle.

Reset
REQ-025 SHALL, while reset is 1, immediately force out_0 to out_3 to 8'h00, out_valid to 4'b0000 and xfer_count to 8'h00, independent of clk.
REQ-026 SHALL hold in_ready at 0 while reset is 1.
REQ-027 SHALL resume normal operation at the first rising clk edge after reset deasserts, with all slots EMPTY.
REQ-028 SHALL, if reset asserts mid-transfer, discard that transfer: it is neither loaded nor counted.

Verification
REQ-029 SHALL cover unicast: reset, then in_select=10, in_data=8'hA5, in_valid=1 for one cycle -> next cycle out_2=A5, out_valid=0100, xfer_count=1; then out_ready=0100 -> out_valid=0000 and out_2 stays A5.
REQ-030 SHALL cover backpressure: channel 1 FULL (8'h11), out_ready=0, in_select=01, in_data=8'h22, in_valid=1 -> in_ready=0, out_1 stays 11, count unchanged; then raise out_ready[1] -> same edge accepts, out_1=22, out_valid[1] stays 1.
REQ-031 SHALL cover broadcast: all EMPTY, in_bcast=1, in_data=8'h3C -> all out_N=3C, out_valid=1111; with channel 3 FULL and not draining, a second broadcast sees in_ready=0 until out_ready[3]=1.
REQ-032 SHALL cover count wrap: 256 back-to-back accepts to channel 0 with out_ready[0]=1 held -> xfer_count returns to 00, out_valid[0] stays 1 throughout, and the final out_0 equals the last byte sent.
REQ-033 SHALL cover async reset: assert reset between clock edges while out_valid=1011 -> outputs clear before the next edge; in_ready=0 during reset; the first accept after release yields xfer_count=1.
REQ-034 SHALL cover independence: channel 0 draining while unicast loads channel 3 in the same cycle -> out_valid goes 0001 to 1000 in one edge.

Source files
------------

// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 byte demultiplexer with per-channel valid/ready holding slots,
// broadcast mode and a wrapping transfer counter.
module demux1x4_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic [1:0] in_select,
    input  logic       in_bcast,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_0,
    output logic [7:0] out_1,
    output logic [7:0] out_2,
    output logic [7:0] out_3,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [7:0] xfer_count
);

    logic [7:0] data_q  [4];
    logic [7:0] data_d  [4];
    logic [3:0] valid_q;
    logic [3:0] valid_d;
    logic [7:0] count_q;
    logic [7:0] count_d;

    logic [3:0] slot_free;
    logic [3:0] load;
    logic [3:0] drain;
    logic       accept;

    // A slot can take a byte if it is empty or is being consumed this same cycle.
    assign slot_free = ~valid_q | out_ready;
    assign drain     = valid_q & out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (in_bcast) begin
                in_ready = &slot_free;
            end else begin
                in_ready = slot_free[in_select];
            end
        end
    end

    assign accept = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign load[gi] = accept & (in_bcast | (in_select == 2'(gi)));

            always_comb begin
                data_d[gi]  = data_q[gi];
                valid_d[gi] = valid_q[gi];
                if (load[gi]) begin
                    data_d[gi]  = in_data;
                    valid_d[gi] = 1'b1;
                end else if (drain[gi]) begin
                    valid_d[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q[gi]  <= 8'h00;
                    valid_q[gi] <= 1'b0;
                end else begin
                    data_q[gi]  <= data_d[gi];
                    valid_q[gi] <= valid_d[gi];
                end
            end
        end
    endgenerate

    assign count_d = accept ? count_q + 8'd1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_0      = data_q[0];
    assign out_1      = data_q[1];
    assign out_2      = data_q[2];
    assign out_3      = data_q[3];
    assign out_valid  = valid_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux1x4_reg.sv
// Bench for demux1x4_reg: directed scenarios followed by random traffic,
// checked against a slot-level reference model.
module tb_demux1x4_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] in_select;
    logic       in_bcast;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_0, out_1, out_2, out_3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] xfer_count;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a mailbox that is either full or empty.
    logic [7:0] m_data [4];
    logic [3:0] m_full;
    int         m_count;

    demux1x4_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_0      (out_0),
        .out_1      (out_1),
        .out_2      (out_2),
        .out_3      (out_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_out(input int n);
        case (n)
            0: return out_0;
            1: return out_1;
            2: return out_2;
            default: return out_3;
        endcase
    endfunction

    function automatic logic model_ready(input logic [1:0] s, input logic b, input logic [3:0] r);
        if (b) begin
            for (int n = 0; n < 4; n++)
                if (m_full[n] && !r[n]) return 1'b0;
            return 1'b1;
        end
        return !m_full[s] || r[s];
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 4; n++) m_data[n] = 8'h00;
        m_full  = 4'b0000;
        m_count = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_full));
        for (int n = 0; n < 4; n++)
            chk($sformatf("%s.out%0d", tag, n), 32'(dut_out(n)), 32'(m_data[n]));
        chk({tag, ".count"}, 32'(xfer_count), 32'(m_count % 256));
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, then check state after the edge.
    task automatic step(input logic v, input logic [1:0] s, input logic b,
                        input logic [7:0] d, input logic [3:0] r, input string tag);
        logic rdy;
        in_valid  = v;
        in_select = s;
        in_bcast  = b;
        in_data   = d;
        out_ready = r;
        #1;
        rdy = model_ready(s, b, r);
        chk({tag, ".ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            if (v && rdy && (b || s == 2'(n))) begin
                m_data[n] = d;
                m_full[n] = 1'b1;
            end else if (m_full[n] && r[n]) begin
                m_full[n] = 1'b0;
            end
        end
        if (v && rdy) m_count++;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_select = 2'b00;
        in_bcast  = 1'b0;
        in_data   = 8'h00;
        out_ready = 4'b0000;
        model_clear();
        #2;
        chk("reset.ready", 32'(in_ready), 32'd0);
        check_outputs("reset");
        do_reset();

        // Unicast to channel 2 then drain it.
        step(1, 2'b10, 0, 8'hA5, 4'b0000, "uni.load");
        chk("uni.out2", 32'(out_2), 32'hA5);
        chk("uni.valid", 32'(out_valid), 32'b0100);
        step(0, 2'b00, 0, 8'h00, 4'b0100, "uni.drain");
        chk("uni.drained", 32'(out_valid), 32'b0000);

        // Backpressure on channel 1, then release with a same-edge reload.
        step(1, 2'b01, 0, 8'h11, 4'b0000, "bp.fill");
        step(1, 2'b01, 0, 8'h22, 4'b0000, "bp.blocked");
        chk("bp.hold", 32'(out_1), 32'h11);
        step(1, 2'b01, 0, 8'h22, 4'b0010, "bp.release");
        chk("bp.new", 32'(out_1), 32'h22);
        step(0, 2'b00, 0, 8'h00, 4'b0010, "bp.empty");

        // Broadcast, then a second broadcast blocked by channel 3.
        step(1, 2'b00, 1, 8'h3C, 4'b0000, "bc.load");
        chk("bc.valid", 32'(out_valid), 32'b1111);
        step(0, 2'b00, 0, 8'h00, 4'b0111, "bc.drain012");
        step(1, 2'b01, 1, 8'h5A, 4'b0000, "bc.blocked");
        step(1, 2'b01, 1, 8'h5A, 4'b0000, "bc.blocked2");
        step(1, 2'b01, 1, 8'h5A, 4'b1000, "bc.release");
        chk("bc.valid2", 32'(out_valid), 32'b1111);

        // Independence: channel 0 drains while channel 3 loads.
        do_reset();
        step(1, 2'b00, 0, 8'h01, 4'b0000, "ind.fill0");
        step(1, 2'b11, 0, 8'h33, 4'b0001, "ind.swap");
        chk("ind.valid", 32'(out_valid), 32'b1000);

        // Counter wrap: 256 back-to-back accepts to channel 0.
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1, 2'b00, 0, 8'($urandom), 4'b0001, $sformatf("wrap%0d", i));
        chk("wrap.count", 32'(xfer_count), 32'd0);
        chk("wrap.v0", 32'(out_valid[0]), 32'd1);

        // Asynchronous reset between edges with out_valid = 1011.
        do_reset();
        step(1, 2'b00, 0, 8'hC0, 4'b0000, "ar.f0");
        step(1, 2'b01, 0, 8'hC1, 4'b0000, "ar.f1");
        step(1, 2'b11, 0, 8'hC3, 4'b0000, "ar.f3");
        chk("ar.pre", 32'(out_valid), 32'b1011);
        #2;
        in_valid  = 1'b1;
        in_select = 2'b10;
        reset     = 1'b1;
        #1;
        model_clear();
        chk("ar.ready", 32'(in_ready), 32'd0);
        check_outputs("ar.async");
        @(posedge clk);
        #1;
        chk("ar.ready2", 32'(in_ready), 32'd0);
        check_outputs("ar.held");
        #2;
        reset = 1'b0;
        #1;
        step(1, 2'b10, 0, 8'h77, 4'b0000, "ar.first");
        chk("ar.count1", 32'(xfer_count), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 7) == 0),
                 8'($urandom), 4'($urandom), $sformatf("rnd%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
